mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16, max bus_ack wait cycles in BUSY before abort.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-004 mem_dest_addr  in  5  destination register from the EX/MEM register.
REQ-005 mem_wreg  in  1  register-write enable from the EX/MEM register.
REQ-006 mem_dest_data  in  32  ALU result from the EX/MEM register.
REQ-007 mem_aluop  in  8  operation code; load/store codes LB_OP, LBU_OP, LH_OP, LHU_OP, LW_OP, SB_OP, SH_OP, SW_OP from the shared defines.
REQ-008 mem_mem_addr  in  32  effective byte address.
REQ-009 mem_src2_data  in  32  store data (rt).
REQ-010 stall  in  6  pipeline stall vector; stall[4] = MEM/WB hold.
REQ-011 bus_req, bus_we  out  1 each  bus request, write strobe.
REQ-012 bus_addr  out  32  word address (byte address with [1:0]=00).
REQ-013 bus_sel  out  4  byte-lane select, bit3 = bits[31:24].
REQ-014 bus_wdata  out  32;  bus_rdata  in  32;  bus_ack  in  1  one-cycle completion.
REQ-015 wb_dest_addr  out  5;  wb_wreg  out  1;  wb_dest_data  out  32  results toward MEM/WB.
REQ-016 stallreq  out  1  stall request to the pipeline controller.
REQ-017 mem_err  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-018 FSM states IDLE, BUSY, DONE; memop = mem_aluop is one of the eight load/store codes.
REQ-019 Non-memop in IDLE: wb_* = mem_dest_* combinationally, stallreq=0, bus_req=0.
REQ-020 IDLE, aligned memop: stallreq=1 combinationally, latch addr/sel/wdata/we, next state BUSY.
REQ-021 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=00; byte ops always aligned.
REQ-022 IDLE, misaligned memop: no bus access, wb_wreg=0, stallreq=0, mem_err pulses next cycle, stay IDLE.
REQ-023 BUSY: bus_req=1 registered, bus_addr/bus_sel/bus_we/bus_wdata stable until bus_ack; stallreq=1.
REQ-024 Big-endian lanes: byte addr[1:0]=00/01/10/11 -> sel 1000/0100/0010/0001; half addr[1]=0/1 -> 1100/0011; word -> 1111.
REQ-025 Stores: byte/half replicated across all lanes of bus_wdata; word = mem_src2_data unchanged.
REQ-026 BUSY & bus_ack: capture bus_rdata, next DONE; bus_req drops in DONE.
REQ-027 BUSY wait counter increments each non-ack cycle; reaching TIMEOUT: drop bus_req, pulse mem_err, next DONE with wb_wreg=0.
REQ-028 DONE: stallreq=0; loads drive wb_dest_data = selected lane, LB/LH sign-extended, LBU/LHU zero-extended, LW whole word; wb_wreg=mem_wreg; stores drive wb_wreg=0.
REQ-029 DONE -> IDLE when stall[4]=0; else hold DONE with captured data stable.
REQ-030 bus_ack outside BUSY ignored; bus_ack on the timeout cycle counts as success (ack wins).
REQ-031 Only one outstanding bus transaction; new memop evaluated only in IDLE.

Reset
REQ-032 rst=0 asynchronously forces IDLE, counter 0, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0000, bus_wdata=0, mem_err=0, captured data 0.
REQ-033 Reset mid-BUSY aborts the transaction immediately; no mem_err pulse; wb_* follow inputs per REQ-019/020 after release.

Verification
REQ-034 LW addr 0x100, ack after 3 cycles, rdata 0x12345678 -> bus_sel 1111, stallreq 1 for 4 cycles, wb_dest_data 0x12345678, wb_wreg 1.
REQ-035 LB addr 0x103, rdata 0x000000F0 -> sel 0001, wb_dest_data 0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-036 SH addr 0x202, src2 0xAAAA5678 -> sel 0011, bus_we 1, bus_wdata 0x56785678, wb_wreg 0.
REQ-037 LW addr 0x101 -> no bus_req, mem_err one pulse, wb_wreg 0, stallreq 0.
REQ-038 LW with no ack, TIMEOUT=16 -> bus_req high 16 cycles, mem_err pulse, wb_wreg 0, return IDLE.
REQ-039 rst low during BUSY -> bus_req 0 same cycle, IDLE after release; then ADD passthrough matches inputs.

Source files
------------

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-bus handshake between the MEM stage and memory
interface mem_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit: one bus transaction at a time,
// big-endian lane select, alignment check and ack timeout.
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        mem_dest_addr,
   input  logic              mem_wreg,
   input  logic [31:0]       mem_dest_data,
   input  logic [7:0]        mem_aluop,
   input  logic [31:0]       mem_mem_addr,
   input  logic [31:0]       mem_src2_data,
   input  logic [5:0]        stall,
   mem_access_if.master      bus,
   output logic [4:0]        wb_dest_addr,
   output logic              wb_wreg,
   output logic [31:0]       wb_dest_data,
   output logic              stallreq,
   output logic              mem_err
);

   localparam logic [7:0] LB_OP  = 8'b11100000;
   localparam logic [7:0] LH_OP  = 8'b11100001;
   localparam logic [7:0] LW_OP  = 8'b11100011;
   localparam logic [7:0] LBU_OP = 8'b11100100;
   localparam logic [7:0] LHU_OP = 8'b11100101;
   localparam logic [7:0] SB_OP  = 8'b11101000;
   localparam logic [7:0] SH_OP  = 8'b11101001;
   localparam logic [7:0] SW_OP  = 8'b11101011;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          timed_out;
   logic [7:0]    op_q;
   logic [1:0]    ofs_q;
   logic [31:0]   rdata_q;

   logic          is_load, is_store, is_byte, is_half, is_word;
   logic          memop, aligned, cnt_last;
   logic [3:0]    sel_c;
   logic [31:0]   wdata_c;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   load_data;

   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[3:0]};

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_byte  = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (mem_aluop)
         LB_OP, LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
         LH_OP, LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
         LW_OP:         begin is_load  = 1'b1; is_word = 1'b1; end
         SB_OP:         begin is_store = 1'b1; is_byte = 1'b1; end
         SH_OP:         begin is_store = 1'b1; is_half = 1'b1; end
         SW_OP:         begin is_store = 1'b1; is_word = 1'b1; end
         default:       ;
      endcase
   end

   assign memop    = is_load | is_store;
   assign aligned  = is_byte | (is_half & ~mem_mem_addr[0]) |
                     (is_word & (mem_mem_addr[1:0] == 2'b00));
   assign cnt_last = (cnt == CW'(TIMEOUT - 1));

   // Big-endian: byte offset 0 lives in bits [31:24].
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = mem_src2_data;
      if (is_byte) begin
         sel_c   = 4'b1000 >> mem_mem_addr[1:0];
         wdata_c = {4{mem_src2_data[7:0]}};
      end else if (is_half) begin
         sel_c   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
         wdata_c = {2{mem_src2_data[15:0]}};
      end
   end

   always_comb begin
      byte_v = rdata_q[31:24];
      case (ofs_q)
         2'b01:   byte_v = rdata_q[23:16];
         2'b10:   byte_v = rdata_q[15:8];
         2'b11:   byte_v = rdata_q[7:0];
         default: byte_v = rdata_q[31:24];
      endcase
      half_v = ofs_q[1] ? rdata_q[15:0] : rdata_q[31:16];
      case (op_q)
         LB_OP:   load_data = {{24{byte_v[7]}}, byte_v};
         LBU_OP:  load_data = {24'h0, byte_v};
         LH_OP:   load_data = {{16{half_v[15]}}, half_v};
         LHU_OP:  load_data = {16'h0, half_v};
         default: load_data = rdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      stallreq     = 1'b0;
      wb_dest_addr = mem_dest_addr;
      wb_wreg      = 1'b0;
      wb_dest_data = mem_dest_data;
      case (state)
         IDLE: begin
            if (!memop) begin
               wb_wreg = mem_wreg;
            end else if (aligned) begin
               stallreq = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            stallreq = 1'b1;
            if (bus.bus_ack || cnt_last) state_nx = DONE;
         end
         DONE: begin
            if (!timed_out && (op_q != SB_OP) && (op_q != SH_OP) && (op_q != SW_OP)) begin
               wb_wreg      = mem_wreg;
               wb_dest_data = load_data;
            end
            if (!stall[4]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bus outputs are registered and only change on entry to / exit from BUSY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 32'h0;
         bus.bus_sel   <= 4'b0000;
         bus.bus_wdata <= 32'h0;
         mem_err       <= 1'b0;
         cnt           <= '0;
         timed_out     <= 1'b0;
         op_q          <= 8'h0;
         ofs_q         <= 2'b00;
         rdata_q       <= 32'h0;
      end else begin
         mem_err <= 1'b0;
         case (state)
            IDLE: begin
               if (memop && aligned) begin
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= is_store;
                  bus.bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                  bus.bus_sel   <= sel_c;
                  bus.bus_wdata <= wdata_c;
                  cnt           <= '0;
                  timed_out     <= 1'b0;
                  op_q          <= mem_aluop;
                  ofs_q         <= mem_mem_addr[1:0];
               end else if (memop) begin
                  mem_err <= 1'b1;
               end
            end
            BUSY: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  bus.bus_we  <= 1'b0;
                  rdata_q     <= bus.bus_rdata;
               end else if (cnt_last) begin
                  bus.bus_req <= 1'b0;
                  bus.bus_we  <= 1'b0;
                  mem_err     <= 1'b1;
                  timed_out   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed-vector bench for mem_access
module tb_mem_access;
   localparam logic [7:0] ADD_OP = 8'b00100000;
   localparam logic [7:0] LB_OP  = 8'b11100000;
   localparam logic [7:0] LH_OP  = 8'b11100001;
   localparam logic [7:0] LW_OP  = 8'b11100011;
   localparam logic [7:0] LBU_OP = 8'b11100100;
   localparam logic [7:0] LHU_OP = 8'b11100101;
   localparam logic [7:0] SB_OP  = 8'b11101000;
   localparam logic [7:0] SH_OP  = 8'b11101001;
   localparam logic [7:0] SW_OP  = 8'b11101011;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_dest_addr;
   logic        mem_wreg;
   logic [31:0] mem_dest_data;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic [31:0] mem_src2_data;
   logic [5:0]  stall;
   logic [4:0]  wb_dest_addr;
   logic        wb_wreg;
   logic [31:0] wb_dest_data;
   logic        stallreq;
   logic        mem_err;

   mem_access_if bus_if ();

   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_src2_data(mem_src2_data),
      .stall(stall), .bus(bus_if),
      .wb_dest_addr(wb_dest_addr), .wb_wreg(wb_wreg), .wb_dest_data(wb_dest_data),
      .stallreq(stallreq), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int          r_stall, r_req, r_err;
   logic        r_stall0, r_wreg0, r_done, r_we, r_wreg;
   logic [3:0]  r_sel;
   logic [31:0] r_baddr, r_wdata, r_data;
   logic [4:0]  r_daddr;

   task automatic set_add(input logic [31:0] data);
      mem_aluop     = ADD_OP;
      mem_dest_addr = 5'd3;
      mem_wreg      = 1'b1;
      mem_dest_data = data;
      mem_mem_addr  = 32'h0;
      mem_src2_data = 32'h0;
   endtask

   // Issues one op at the current negedge and follows it until the MEM stage releases.
   task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] src2,
                         input int ack_at, input logic [31:0] rdata);
      r_stall = 0; r_req = 0; r_err = 0; r_done = 1'b0;
      r_stall0 = 1'b0; r_wreg0 = 1'b0; r_we = 1'b0; r_wreg = 1'b0;
      r_sel = 4'h0; r_baddr = 32'h0; r_wdata = 32'h0; r_data = 32'h0; r_daddr = 5'h0;
      mem_aluop = op; mem_mem_addr = addr; mem_src2_data = src2;
      mem_dest_addr = 5'd7; mem_wreg = 1'b1; mem_dest_data = 32'hDEADBEEF;
      for (int c = 0; c < 64; c++) begin
         if (c > 0) @(negedge clk);
         bus_if.bus_ack = 1'b0;
         if (c == 1 && !r_stall0) set_add(32'h0);
         #1;
         if (c == 0) begin r_stall0 = stallreq; r_wreg0 = wb_wreg; end
         if (stallreq) r_stall++;
         if (mem_err) r_err++;
         if (bus_if.bus_req) begin
            r_req++;
            if (r_req == 1) begin
               r_sel = bus_if.bus_sel; r_we = bus_if.bus_we;
               r_baddr = bus_if.bus_addr; r_wdata = bus_if.bus_wdata;
            end
            if (r_req == ack_at) begin bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata; end
         end
         if (c > 0 && !stallreq) begin
            r_wreg = wb_wreg; r_data = wb_dest_data; r_daddr = wb_dest_addr;
            r_done = 1'b1;
            break;
         end
      end
   endtask

   // Pipeline advances past the op: next instruction is an ADD; catch any late mem_err.
   task automatic post_cycle();
      @(negedge clk);
      set_add(32'h0);
      #1;
      if (mem_err) r_err++;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus_if.bus_req); end
      n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", bus_if.bus_we); end
      n_cmp++; if (bus_if.bus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus_if.bus_addr); end
      n_cmp++; if (bus_if.bus_sel !== 4'b0000) begin n_bad++; $display("FAIL rst_sel got %b want 0000", bus_if.bus_sel); end
      n_cmp++; if (bus_if.bus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", bus_if.bus_wdata); end
      n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", mem_err); end
      n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rst_stallreq got %b want 0", stallreq); end
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      set_add(32'hCAFEF00D);
      #1;
      n_cmp++; if (wb_dest_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL pass_data got %h want cafef00d", wb_dest_data); end
      n_cmp++; if (wb_dest_addr !== 5'd3) begin n_bad++; $display("FAIL pass_addr got %0d want 3", wb_dest_addr); end
      n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("FAIL pass_wreg got %b want 1", wb_wreg); end
      mem_wreg = 1'b0;
      #1;
      n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("FAIL pass_wreg0 got %b want 0", wb_wreg); end
   endtask

   task automatic test_lw();
      @(negedge clk);
      run_op(LW_OP, 32'h100, 32'h0, 3, 32'h12345678);
      post_cycle();
      n_cmp++; if (r_done !== 1'b1) begin n_bad++; $display("FAIL lw_done got %b want 1", r_done); end
      n_cmp++; if (r_stall != 4) begin n_bad++; $display("FAIL lw_stall_cycles got %0d want 4", r_stall); end
      n_cmp++; if (r_req != 3) begin n_bad++; $display("FAIL lw_req_cycles got %0d want 3", r_req); end
      n_cmp++; if (r_sel !== 4'b1111) begin n_bad++; $display("FAIL lw_sel got %b want 1111", r_sel); end
      n_cmp++; if (r_baddr !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 100", r_baddr); end
      n_cmp++; if (r_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %b want 0", r_we); end
      n_cmp++; if (r_data !== 32'h12345678) begin n_bad++; $display("FAIL lw_data got %h want 12345678", r_data); end
      n_cmp++; if (r_wreg !== 1'b1) begin n_bad++; $display("FAIL lw_wreg got %b want 1", r_wreg); end
      n_cmp++; if (r_daddr !== 5'd7) begin n_bad++; $display("FAIL lw_daddr got %0d want 7", r_daddr); end
      n_cmp++; if (r_err != 0) begin n_bad++; $display("FAIL lw_err got %0d want 0", r_err); end
   endtask

   task automatic test_sub_word_loads();
      @(negedge clk);
      run_op(LB_OP, 32'h103, 32'h0, 1, 32'h000000F0);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b0001) begin n_bad++; $display("FAIL lb_sel got %b want 0001", r_sel); end
      n_cmp++; if (r_baddr !== 32'h100) begin n_bad++; $display("FAIL lb_addr got %h want 100", r_baddr); end
      n_cmp++; if (r_data !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL lb_data got %h want fffffff0", r_data); end
      @(negedge clk);
      run_op(LBU_OP, 32'h103, 32'h0, 1, 32'h000000F0);
      post_cycle();
      n_cmp++; if (r_data !== 32'h000000F0) begin n_bad++; $display("FAIL lbu_data got %h want 000000f0", r_data); end
      @(negedge clk);
      run_op(LB_OP, 32'h101, 32'h0, 2, 32'h11A23344);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b0100) begin n_bad++; $display("FAIL lb1_sel got %b want 0100", r_sel); end
      n_cmp++; if (r_data !== 32'hFFFFFFA2) begin n_bad++; $display("FAIL lb1_data got %h want ffffffa2", r_data); end
      @(negedge clk);
      run_op(LH_OP, 32'h102, 32'h0, 1, 32'h00008001);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b0011) begin n_bad++; $display("FAIL lh_sel got %b want 0011", r_sel); end
      n_cmp++; if (r_data !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_data got %h want ffff8001", r_data); end
      @(negedge clk);
      run_op(LHU_OP, 32'h100, 32'h0, 1, 32'h80010000);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b1100) begin n_bad++; $display("FAIL lhu_sel got %b want 1100", r_sel); end
      n_cmp++; if (r_data !== 32'h00008001) begin n_bad++; $display("FAIL lhu_data got %h want 00008001", r_data); end
   endtask

   task automatic test_stores();
      @(negedge clk);
      run_op(SH_OP, 32'h202, 32'hAAAA5678, 1, 32'h0);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b0011) begin n_bad++; $display("FAIL sh_sel got %b want 0011", r_sel); end
      n_cmp++; if (r_we !== 1'b1) begin n_bad++; $display("FAIL sh_we got %b want 1", r_we); end
      n_cmp++; if (r_wdata !== 32'h56785678) begin n_bad++; $display("FAIL sh_wdata got %h want 56785678", r_wdata); end
      n_cmp++; if (r_baddr !== 32'h200) begin n_bad++; $display("FAIL sh_addr got %h want 200", r_baddr); end
      n_cmp++; if (r_wreg !== 1'b0) begin n_bad++; $display("FAIL sh_wreg got %b want 0", r_wreg); end
      @(negedge clk);
      run_op(SB_OP, 32'h201, 32'h99887712, 2, 32'h0);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b0100) begin n_bad++; $display("FAIL sb_sel got %b want 0100", r_sel); end
      n_cmp++; if (r_wdata !== 32'h12121212) begin n_bad++; $display("FAIL sb_wdata got %h want 12121212", r_wdata); end
      @(negedge clk);
      run_op(SW_OP, 32'h300, 32'hA1B2C3D4, 1, 32'h0);
      post_cycle();
      n_cmp++; if (r_sel !== 4'b1111) begin n_bad++; $display("FAIL sw_sel got %b want 1111", r_sel); end
      n_cmp++; if (r_wdata !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL sw_wdata got %h want a1b2c3d4", r_wdata); end
      n_cmp++; if (r_wreg !== 1'b0) begin n_bad++; $display("FAIL sw_wreg got %b want 0", r_wreg); end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      run_op(LW_OP, 32'h101, 32'h0, 1, 32'h0);
      post_cycle();
      n_cmp++; if (r_req != 0) begin n_bad++; $display("FAIL mis_lw_req got %0d want 0", r_req); end
      n_cmp++; if (r_err != 1) begin n_bad++; $display("FAIL mis_lw_err got %0d want 1", r_err); end
      n_cmp++; if (r_wreg0 !== 1'b0) begin n_bad++; $display("FAIL mis_lw_wreg got %b want 0", r_wreg0); end
      n_cmp++; if (r_stall0 !== 1'b0) begin n_bad++; $display("FAIL mis_lw_stallreq got %b want 0", r_stall0); end
      @(negedge clk);
      run_op(SH_OP, 32'h203, 32'h1234, 1, 32'h0);
      post_cycle();
      n_cmp++; if (r_req != 0) begin n_bad++; $display("FAIL mis_sh_req got %0d want 0", r_req); end
      n_cmp++; if (r_err != 1) begin n_bad++; $display("FAIL mis_sh_err got %0d want 1", r_err); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      run_op(LW_OP, 32'h100, 32'h0, 0, 32'h0);
      post_cycle();
      n_cmp++; if (r_done !== 1'b1) begin n_bad++; $display("FAIL to_done got %b want 1", r_done); end
      n_cmp++; if (r_req != 16) begin n_bad++; $display("FAIL to_req_cycles got %0d want 16", r_req); end
      n_cmp++; if (r_err != 1) begin n_bad++; $display("FAIL to_err got %0d want 1", r_err); end
      n_cmp++; if (r_wreg !== 1'b0) begin n_bad++; $display("FAIL to_wreg got %b want 0", r_wreg); end
      n_cmp++; if (r_stall != 17) begin n_bad++; $display("FAIL to_stall_cycles got %0d want 17", r_stall); end
      n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("FAIL to_idle_pass got %b want 1", wb_wreg); end
      @(negedge clk);
      run_op(LW_OP, 32'h100, 32'h0, 16, 32'h5A5A0001);
      post_cycle();
      n_cmp++; if (r_err != 0) begin n_bad++; $display("FAIL ackwin_err got %0d want 0", r_err); end
      n_cmp++; if (r_wreg !== 1'b1) begin n_bad++; $display("FAIL ackwin_wreg got %b want 1", r_wreg); end
      n_cmp++; if (r_data !== 32'h5A5A0001) begin n_bad++; $display("FAIL ackwin_data got %h want 5a5a0001", r_data); end
   endtask

   task automatic test_hold();
      stall = 6'b010000;
      @(negedge clk);
      run_op(LW_OP, 32'h104, 32'h0, 1, 32'h89ABCDEF);
      @(negedge clk);
      #1;
      n_cmp++; if (wb_dest_data !== 32'h89ABCDEF) begin n_bad++; $display("FAIL hold_data got %h want 89abcdef", wb_dest_data); end
      n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL hold_stallreq got %b want 0", stallreq); end
      n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL hold_req got %b want 0", bus_if.bus_req); end
      stall = 6'b000000;
      @(negedge clk);
      set_add(32'h11112222);
      #1;
      n_cmp++; if (wb_dest_data !== 32'h11112222) begin n_bad++; $display("FAIL hold_release got %h want 11112222", wb_dest_data); end
   endtask

   task automatic test_ack_idle();
      @(negedge clk);
      set_add(32'h0);
      bus_if.bus_ack = 1'b1;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      #1;
      n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL ackidle_req got %b want 0", bus_if.bus_req); end
      n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL ackidle_err got %b want 0", mem_err); end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      mem_aluop = LW_OP; mem_mem_addr = 32'h100; mem_wreg = 1'b1; mem_dest_addr = 5'd9;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_bad++; $display("FAIL rb_busy_req got %b want 1", bus_if.bus_req); end
      rst = 1'b0;
      #1;
      n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rb_req got %b want 0", bus_if.bus_req); end
      n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rb_err got %b want 0", mem_err); end
      @(negedge clk);
      rst = 1'b1;
      set_add(32'h0BADF00D);
      #1;
      n_cmp++; if (wb_dest_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL rb_pass_data got %h want 0badf00d", wb_dest_data); end
      n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rb_stallreq got %b want 0", stallreq); end
      @(negedge clk);
      #1;
      n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rb_err_after got %b want 0", mem_err); end
      n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rb_req_after got %b want 0", bus_if.bus_req); end
   endtask

   initial begin
      rst = 1'b0;
      stall = 6'b000000;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = 32'h0;
      set_add(32'h0);
      @(negedge clk);
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      test_passthrough();
      test_lw();
      test_sub_word_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_hold();
      test_ack_idle();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
